// File: rtl/alu_exec_unit.sv
// EX-stage ALU with folded aluop/funct decode and an iterative multiply/divide unit with HI/LO.
// Optional feature macro: ALU_MULDIV_EN (mult/div FSM, HI/LO registers, mfhi/mflo/mthi/mtlo).
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_BAD
    } op_e;

    op_e op;

    // aluop/funct decode; mult/div family only exists when the unit is built in
    always_comb begin
        op = OP_BAD;
        case (aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
`ifdef ALU_MULDIV_EN
                    6'b011000: op = OP_MULT;
                    6'b011001: op = OP_MULTU;
                    6'b011010: op = OP_DIV;
                    6'b011011: op = OP_DIVU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    6'b010001: op = OP_MTHI;
                    6'b010011: op = OP_MTLO;
`endif
                    default:   op = OP_BAD;
                endcase
            end
            default: op = OP_BAD;
        endcase
    end

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = srca + srcb;
            OP_SUB:  result = srca - srcb;
            OP_AND:  result = srca & srcb;
            OP_OR:   result = srca | srcb;
            OP_XOR:  result = srca ^ srcb;
            OP_NOR:  result = ~(srca | srcb);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, srca < srcb};
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    assign zero    = (result == '0);
    assign illegal = valid_in & (op == OP_BAD);

`ifdef ALU_MULDIV_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               is_muldiv;
    logic               is_signed;
    logic               op_div;
    logic               start;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign start     = valid_in & is_muldiv & ~flush & (state == S_IDLE);
    assign abs_a     = (is_signed && srca[WIDTH-1]) ? ('0 - srca) : srca;
    assign abs_b     = (is_signed && srcb[WIDTH-1]) ? ('0 - srcb) : srcb;

    // Shared datapath: {acc_hi, acc_lo} is product register for mul, {remainder, quotient} for div
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign prod_fix  = neg_q ? ('0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    assign quot_fix  = neg_q ? ('0 - acc_lo) : acc_lo;
    assign rem_fix   = neg_r ? ('0 - acc_hi) : acc_hi;

    assign stall = start | (state == S_MUL) | (state == S_DIV);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            count  <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            is_div <= op_div;
                            if (op_div && (srcb == '0)) begin
                                // Divide by zero: skip iteration, FIX writes hi=srca, lo=all ones
                                acc_hi <= srca;
                                acc_lo <= '1;
                                neg_q  <= 1'b0;
                                neg_r  <= 1'b0;
                                count  <= '0;
                                state  <= S_FIX;
                                done   <= 1'b1;
                            end else begin
                                neg_q  <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                                neg_r  <= is_signed & srca[WIDTH-1];
                                acc_hi <= '0;
                                acc_lo <= op_div ? abs_a : abs_b;
                                opnd   <= op_div ? abs_b : abs_a;
                                count  <= CW'(WIDTH);
                                state  <= op_div ? S_DIV : S_MUL;
                            end
                        end else if (valid_in && op == OP_MTHI) begin
                            hi <= srca;
                        end else if (valid_in && op == OP_MTLO) begin
                            lo <= srca;
                        end
                    end
                    S_MUL: begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= S_FIX;
                            done  <= 1'b1;
                        end
                    end
                    S_DIV: begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= S_FIX;
                            done  <= 1'b1;
                        end
                    end
                    S_FIX: begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{clk, reset_n, flush};
    assign stall     = 1'b0;
    assign done      = 1'b0;
    assign hi        = '0;
    assign lo        = '0;
`endif

endmodule
